// File: rtl/imm_pkg.sv
// imm_pkg: shared definitions for the immediate generator pipeline.
// Holds the immediate-format select encoding and the legal XLEN values.
package imm_pkg;

   // Immediate format select carried on in_imm_src.
   typedef enum logic [2:0] {
      IMM_I     = 3'b000,
      IMM_S     = 3'b001,
      IMM_B     = 3'b010,
      IMM_J     = 3'b011,
      IMM_U     = 3'b100,
      IMM_Z     = 3'b101,
      IMM_SHAMT = 3'b110,
      IMM_UNDEF = 3'b111
   } imm_src_e;

   // Legal immediate widths.
   localparam int unsigned XLEN_RV32 = 32;
   localparam int unsigned XLEN_RV64 = 64;

endpackage

// File: rtl/imm_fifo.sv
// imm_fifo: parametrised synchronous FIFO with valid/ready on both sides.
// DEPTH must be a power of two so the pointers wrap by natural overflow.
// The read data is forced to zero while empty so the output never shows
// stale or uninitialised storage.
module imm_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             push_valid,
   output logic             push_ready,
   input  logic [WIDTH-1:0] push_data,
   output logic             pop_valid,
   input  logic             pop_ready,
   output logic [WIDTH-1:0] pop_data
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign push_ready = (count < FULL_CNT);
   assign pop_valid  = (count != '0);
   assign do_push    = push_valid && push_ready;
   assign do_pop     = pop_valid && pop_ready;
   assign pop_data   = pop_valid ? mem[rd_ptr] : '0;

   // Pointer and occupancy tracking; reset beats flush, flush beats handshakes.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage write; a push coinciding with reset or flush is dropped.
   always_ff @(posedge clk) begin
      if (!reset && !flush && do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: RISC-V immediate generator followed by a small output FIFO.
// Decodes the immediate combinationally from the incoming instruction and
// buffers {imm, tag[, err]} so results appear no earlier than one cycle
// after acceptance.
// Optional feature macro: IMM_ERR_EN adds an out_err port and a per-entry
// flag that marks the undefined format select code.
module imm_gen_pipe
   import imm_pkg::*;
#(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned DEPTH = 2,
   parameter int unsigned TAG_W = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_inst,
   input  logic [2:0]       in_imm_src,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_imm,
   output logic [TAG_W-1:0] out_tag
`ifdef IMM_ERR_EN
   ,
   output logic             out_err
`endif
);

`ifdef IMM_ERR_EN
   localparam int unsigned ENTRY_W = XLEN + TAG_W + 1;
`else
   localparam int unsigned ENTRY_W = XLEN + TAG_W;
`endif

   logic [XLEN-1:0]    imm;
   logic [ENTRY_W-1:0] push_data;
   logic [ENTRY_W-1:0] pop_data;
   logic               unused_opcode;

   // The opcode field never contributes to any immediate.
   assign unused_opcode = ^in_inst[6:0];

   // Format decode; signed casts sign-extend from inst[31] to XLEN.
   always_comb begin
      imm = '0;
      case (imm_src_e'(in_imm_src))
         IMM_I:     imm = XLEN'($signed(in_inst[31:20]));
         IMM_S:     imm = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
         IMM_B:     imm = XLEN'($signed({in_inst[31], in_inst[7], in_inst[30:25],
                                         in_inst[11:8], 1'b0}));
         IMM_J:     imm = XLEN'($signed({in_inst[31], in_inst[19:12], in_inst[20],
                                         in_inst[30:21], 1'b0}));
         IMM_U:     imm = XLEN'($signed({in_inst[31:12], 12'b0}));
         IMM_Z:     imm = XLEN'(in_inst[19:15]);
         IMM_SHAMT: imm = (XLEN == XLEN_RV64) ? XLEN'(in_inst[25:20])
                                              : XLEN'(in_inst[24:20]);
         default:   imm = '0;
      endcase
   end

`ifdef IMM_ERR_EN
   assign push_data = {imm, in_tag, (in_imm_src == IMM_UNDEF)};
   assign out_err   = pop_data[0];
`else
   assign push_data = {imm, in_tag};
`endif

   assign out_imm = pop_data[ENTRY_W-1 -: XLEN];
   assign out_tag = pop_data[ENTRY_W-XLEN-1 -: TAG_W];

   imm_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .flush      (flush),
      .push_valid (in_valid),
      .push_ready (in_ready),
      .push_data  (push_data),
      .pop_valid  (out_valid),
      .pop_ready  (out_ready),
      .pop_data   (pop_data)
   );

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: directed self-checking bench for imm_gen_pipe.
// Two instances share clock/reset/flush: an XLEN=32 one carrying the FIFO
// scenarios and an XLEN=64 one for wide sign/zero extension.
// Honours IMM_ERR_EN to connect and check out_err.
module tb_imm_gen_pipe;

   logic clk = 1'b0;
   logic reset;
   logic flush;

   logic        iv32, ir32, ov32, or32;
   logic [31:0] inst32;
   logic [2:0]  src32;
   logic [4:0]  tag32, otag32;
   logic [31:0] oimm32;

   logic        iv64, ir64, ov64, or64;
   logic [31:0] inst64;
   logic [2:0]  src64;
   logic [4:0]  tag64, otag64;
   logic [63:0] oimm64;

`ifdef IMM_ERR_EN
   logic err32, err64;
`endif

   int compared = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   imm_gen_pipe #(.XLEN(32), .DEPTH(2), .TAG_W(5)) dut32 (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(iv32), .in_ready(ir32), .in_inst(inst32), .in_imm_src(src32), .in_tag(tag32),
      .out_valid(ov32), .out_ready(or32), .out_imm(oimm32), .out_tag(otag32)
`ifdef IMM_ERR_EN
      , .out_err(err32)
`endif
   );

   imm_gen_pipe #(.XLEN(64), .DEPTH(2), .TAG_W(5)) dut64 (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(iv64), .in_ready(ir64), .in_inst(inst64), .in_imm_src(src64), .in_tag(tag64),
      .out_valid(ov64), .out_ready(or64), .out_imm(oimm64), .out_tag(otag64)
`ifdef IMM_ERR_EN
      , .out_err(err64)
`endif
   );

   task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", nm, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send32(input logic [31:0] inst, input logic [2:0] src, input logic [4:0] tag);
      iv32 = 1'b1; inst32 = inst; src32 = src; tag32 = tag;
      tick();
      iv32 = 1'b0;
   endtask

   task automatic pop32();
      or32 = 1'b1;
      tick();
      or32 = 1'b0;
   endtask

   // One push, check no same-cycle visibility, check result, drain.
   task automatic vec32(input string nm, input logic [31:0] inst, input logic [2:0] src,
                        input logic [4:0] tag, input logic [63:0] exp);
      iv32 = 1'b1; inst32 = inst; src32 = src; tag32 = tag;
      chk({nm, "_nobypass"}, 64'(ov32), 64'd0);
      tick();
      iv32 = 1'b0;
      chk({nm, "_valid"}, 64'(ov32), 64'd1);
      chk({nm, "_imm"}, 64'(oimm32), exp);
      chk({nm, "_tag"}, 64'(otag32), 64'(tag));
`ifdef IMM_ERR_EN
      chk({nm, "_err"}, 64'(err32), 64'd0);
`endif
      pop32();
      chk({nm, "_drained"}, 64'(ov32), 64'd0);
   endtask

   task automatic vec64(input string nm, input logic [31:0] inst, input logic [2:0] src,
                        input logic [4:0] tag, input logic [63:0] exp);
      iv64 = 1'b1; inst64 = inst; src64 = src; tag64 = tag;
      tick();
      iv64 = 1'b0;
      chk({nm, "_valid"}, 64'(ov64), 64'd1);
      chk({nm, "_imm"}, oimm64, exp);
      chk({nm, "_tag"}, 64'(otag64), 64'(tag));
      or64 = 1'b1;
      tick();
      or64 = 1'b0;
      chk({nm, "_drained"}, 64'(ov64), 64'd0);
   endtask

   initial begin
      reset = 1'b1; flush = 1'b0;
      iv32 = 1'b0; or32 = 1'b0; inst32 = '0; src32 = '0; tag32 = '0;
      iv64 = 1'b0; or64 = 1'b0; inst64 = '0; src64 = '0; tag64 = '0;
      tick();
      tick();
      reset = 1'b0;

      // Reset state
      chk("rst_ov32",   64'(ov32),   64'd0);
      chk("rst_ir32",   64'(ir32),   64'd1);
      chk("rst_imm32",  64'(oimm32), 64'd0);
      chk("rst_tag32",  64'(otag32), 64'd0);
      chk("rst_ov64",   64'(ov64),   64'd0);
      chk("rst_imm64",  oimm64,      64'd0);
`ifdef IMM_ERR_EN
      chk("rst_err32",  64'(err32),  64'd0);
`endif

      // XLEN=32 format decode
      vec32("i_neg",  32'hFFF00093, 3'b000, 5'h15, 64'h0000_0000_FFFF_FFFF);
      vec32("i_pos",  32'h7FF00093, 3'b000, 5'h02, 64'h0000_0000_0000_07FF);
      vec32("s_neg",  32'hFE112E23, 3'b001, 5'h03, 64'h0000_0000_FFFF_FFFC);
      vec32("b_pos",  32'h00000463, 3'b010, 5'h04, 64'h0000_0000_0000_0008);
      vec32("j_pos",  32'h0080006F, 3'b011, 5'h05, 64'h0000_0000_0000_0008);
      vec32("u_pos",  32'h12345037, 3'b100, 5'h06, 64'h0000_0000_1234_5000);
      vec32("u_neg",  32'h80000037, 3'b100, 5'h07, 64'h0000_0000_8000_0000);
      vec32("z_zext", 32'h800F8073, 3'b101, 5'h08, 64'h0000_0000_0000_001F);
      vec32("shamt5", 32'h03F01013, 3'b110, 5'h09, 64'h0000_0000_0000_001F);

      // Undefined select yields zero (and flags err when enabled)
      send32(32'hFFFFFFFF, 3'b111, 5'h1F);
      chk("undef32_valid", 64'(ov32),   64'd1);
      chk("undef32_imm",   64'(oimm32), 64'd0);
      chk("undef32_tag",   64'(otag32), 64'h1F);
`ifdef IMM_ERR_EN
      chk("undef32_err",   64'(err32),  64'd1);
`endif
      pop32();

      // Fill with out_ready low: third push refused, order kept, head stable
      or32 = 1'b0;
      iv32 = 1'b1; src32 = 3'b000;
      inst32 = 32'h00100093; tag32 = 5'h01;
      tick();
      chk("fill_ready_after1", 64'(ir32), 64'd1);
      inst32 = 32'h00200093; tag32 = 5'h02;
      tick();
      chk("fill_ready_after2", 64'(ir32), 64'd0);
      inst32 = 32'h00300093; tag32 = 5'h03;
      tick();
      iv32 = 1'b0;
      chk("fill_ready_after3", 64'(ir32),   64'd0);
      chk("fill_head_imm",     64'(oimm32), 64'd1);
      tick();
      chk("fill_hold_imm",     64'(oimm32), 64'd1);
      chk("fill_hold_tag",     64'(otag32), 64'd1);
      pop32();
      chk("drain_second_imm",  64'(oimm32), 64'd2);
      chk("drain_second_tag",  64'(otag32), 64'd2);
      pop32();
      chk("drain_third_absent", 64'(ov32), 64'd0);

      // Full FIFO: push attempt and pop together -> only the pop happens
      send32(32'h00A00093, 3'b000, 5'h0A);
      send32(32'h00B00093, 3'b000, 5'h0B);
      chk("full_ready", 64'(ir32), 64'd0);
      iv32 = 1'b1; inst32 = 32'h00C00093; tag32 = 5'h0C; or32 = 1'b1;
      tick();
      iv32 = 1'b0; or32 = 1'b0;
      chk("fullpop_valid", 64'(ov32),   64'd1);
      chk("fullpop_ready", 64'(ir32),   64'd1);
      chk("fullpop_head",  64'(oimm32), 64'h00B);
      pop32();
      chk("fullpop_count1", 64'(ov32), 64'd0);

      // Flush with a same-cycle push and pop while two entries are held
      send32(32'h00D00093, 3'b000, 5'h0D);
      send32(32'h00E00093, 3'b000, 5'h0E);
      flush = 1'b1; iv32 = 1'b1; inst32 = 32'h00F00093; tag32 = 5'h0F; or32 = 1'b1;
      tick();
      flush = 1'b0; iv32 = 1'b0; or32 = 1'b0;
      chk("flush_ov",    64'(ov32),   64'd0);
      chk("flush_ready", 64'(ir32),   64'd1);
      chk("flush_imm",   64'(oimm32), 64'd0);
      tick();
      chk("flush_stays_empty", 64'(ov32), 64'd0);
      vec32("post_flush", 32'h01000093, 3'b000, 5'h10, 64'h0000_0000_0000_0010);

      // Reset mid-stream with handshakes active
      send32(32'h01100093, 3'b000, 5'h11);
      reset = 1'b1; iv32 = 1'b1; inst32 = 32'h01200093; or32 = 1'b1;
      tick();
      reset = 1'b0; iv32 = 1'b0; or32 = 1'b0;
      chk("midrst_ov",    64'(ov32), 64'd0);
      chk("midrst_ready", 64'(ir32), 64'd1);
      tick();
      chk("midrst_stays_empty", 64'(ov32), 64'd0);

      // XLEN=64 extension
      vec64("b64_neg",   32'hFE000EE3, 3'b010, 5'h01, 64'hFFFF_FFFF_FFFF_FFFC);
      vec64("u64_neg",   32'h80000037, 3'b100, 5'h02, 64'hFFFF_FFFF_8000_0000);
      vec64("i64_neg",   32'hFFF00093, 3'b000, 5'h03, 64'hFFFF_FFFF_FFFF_FFFF);
      vec64("s64_pos",   32'h00112623, 3'b001, 5'h04, 64'h0000_0000_0000_000C);
      vec64("shamt64",   32'h03F01013, 3'b110, 5'h05, 64'h0000_0000_0000_003F);
      vec64("z64_zext",  32'h800F8073, 3'b101, 5'h06, 64'h0000_0000_0000_001F);

      iv64 = 1'b1; inst64 = 32'hFFFFFFFF; src64 = 3'b111; tag64 = 5'h07;
      tick();
      iv64 = 1'b0;
      chk("undef64_imm", oimm64, 64'd0);
`ifdef IMM_ERR_EN
      chk("undef64_err", 64'(err64), 64'd1);
`endif
      or64 = 1'b1;
      tick();
      or64 = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, immediate width; legal values 32 and 64.
REQ-002 SHALL have parameter DEPTH, default 2, buffer entries; legal values are powers of two from 2 to 8.
REQ-003 SHALL have parameter TAG_W, default 5, width of the sideband tag carried with each immediate.
REQ-004 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port flush, input, 1, discards all buffered and incoming entries.
REQ-007 SHALL have port in_valid, input, 1, upstream offers an instruction.
REQ-008 SHALL have port in_ready, output, 1, the block accepts an instruction this cycle.
REQ-009 SHALL have port in_inst, input, 32, raw instruction word.
REQ-010 SHALL have port in_imm_src, input, 3, immediate format select.
REQ-011 SHALL have port in_tag, input, TAG_W, sideband returned unchanged with the result.
REQ-012 SHALL have port out_valid, output, 1, the head entry is valid.
REQ-013 SHALL have port out_ready, input, 1, downstream consumes the head entry.
REQ-014 SHALL have port out_imm, output, XLEN, extended immediate of the head entry.
REQ-015 SHALL have port out_tag, output, TAG_W, tag of the head entry.
REQ-016 SHALL have port out_err, output, 1, head entry had an undefined in_imm_src code; present only under IMM_ERR_EN.

Function
REQ-017 SHALL decode in_imm_src as: 000 I, 001 S, 010 B, 011 J, 100 U, 101 Z, 110 SHAMT, 111 undefined.
REQ-018 SHALL build formats I, S, B, J, U per RV32I bit placement, with B and J having bit0 = 0 and I, S, B, J, U sign-extended from inst[31] to XLEN.
REQ-019 SHALL build Z as inst[19:15] zero-extended (CSR uimm), and SHAMT as inst[24:20] (XLEN=32) or inst[25:20] (XLEN=64) zero-extended.
REQ-020 SHALL produce all-zero out_imm for the undefined code, never X.
REQ-021 SHALL push {imm, tag, err} into a DEPTH-entry FIFO when in_valid and in_ready are both high.
REQ-022 SHALL pop the head entry when out_valid and out_ready are both high.
REQ-023 SHALL drive in_ready = (count < DEPTH), with no same-cycle pass-through when full.
REQ-024 SHALL drive out_valid = (count != 0), with no input-to-output bypass; an entry accepted in cycle N is visible at the earliest in cycle N+1.
REQ-025 SHALL update count by +1, -1, or 0 on simultaneous push and pop when neither full nor empty.
REQ-026 SHALL wrap read and write pointers modulo DEPTH.
REQ-027 SHALL hold out_imm and out_tag stable while out_valid is high and out_ready is low.
REQ-028 SHALL, on flush, clear count and pointers at the next edge, ignore a same-cycle push, and treat a same-cycle pop as part of the clear.
REQ-029 SHALL give reset priority over flush, and flush priority over push and pop.

Reset
REQ-030 SHALL, after reset, hold count=0, pointers=0, out_valid=0, in_ready=1, out_imm=0, out_tag=0, out_err=0.
REQ-031 SHALL, when reset is asserted mid-stream, discard all entries at that edge regardless of handshakes.

Configuration
REQ-032 SHALL, when IMM_ERR_EN is defined, store an err bit per entry that is set for code 111 and present it on out_err with the head entry.
REQ-033 SHALL, when IMM_ERR_EN is undefined, omit the out_err port and the err storage; code 111 still yields zero.

Structure
REQ-034 SHALL place the imm_src enum (IMM_I through IMM_SHAMT, IMM_UNDEF) and the XLEN legality constants in shared package imm_pkg.
REQ-035 SHALL implement storage in sub-module imm_fifo, a parametrised width/DEPTH synchronous FIFO; format decode SHALL stay in imm_gen_pipe.

Verification
REQ-036 SHALL cover: inst 32'hFFF00093, src 000, XLEN=32 -> out_imm 32'hFFFFFFFF one cycle later, tag preserved.
REQ-037 SHALL cover: B-type inst 32'hFE000EE3, src 010, XLEN=64 -> out_imm 64'hFFFFFFFFFFFFFFFC.
REQ-038 SHALL cover: DEPTH=2, out_ready=0, three pushes -> in_ready=0 after second push, third not accepted, order preserved on drain.
REQ-039 SHALL cover: full FIFO with push attempt and pop in the same cycle -> one pop only, count becomes 1.
REQ-040 SHALL cover: flush with in_valid=1 while 2 entries are held -> out_valid=0 the next cycle and the flushed push is never output.
REQ-041 SHALL cover: src 111 with IMM_ERR_EN -> out_imm=0 and out_err=1; without IMM_ERR_EN -> out_imm=0.
